bitwise_logic_pipe: RTL and testbench
=====================================

// Module: bitwise_logic_pipe
// PURPOSE
//  Parametrised, pipelined bitwise logic unit; successor to the fixed 32-bit combinational AND.
//  Selects one of 8 bitwise ops per transaction and returns a registered result plus zero flag.
//  Uses valid/ready handshakes on both sides and keeps a wrapping count of completed results.
//  Sits between operand source (regfile/test driver) and writeback/result sink in the lab datapath.
// PARAMETERS
//  WIDTH      32  operand/result width in bits, >=1
//  CNT_WIDTH  16  width of completed-transaction counter, >=1
// PORTS
//  clk        in   1          rising-edge clock
//  rst_n      in   1          asynchronous active-low reset
//  in_valid   in   1          operand transfer request
//  in_ready   out  1          unit can accept operands this cycle
//  in_a       in   WIDTH      operand A
//  in_b       in   WIDTH      operand B
//  in_op      in   3          op select (see BEHAVIOUR)
//  out_valid  out  1          result valid
//  out_ready  in   1          sink accepts result this cycle
//  out_res    out  WIDTH      result
//  out_zero   out  1          1 when out_res == 0
//  cnt_clr    in   1          synchronous clear of out_count
//  out_count  out  CNT_WIDTH  completed results (out_valid & out_ready), wraps
// BEHAVIOUR
//  - Ops: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (A & ~B), 7 PASS_A.
//  - Two register stages: S1 captures {a,b,op}; S2 captures {res,zero}. Latency 2 cycles in->out.
//  - Input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
//  - s2_adv = !s2_valid | out_ready; s1_adv = !s1_valid | s2_adv; in_ready = s1_adv (combinational).
//  - Full throughput (1 txn/cycle) while out_ready held high; no bubble inserted on stall release.
//  - Stall: while out_valid & !out_ready, out_res/out_zero/out_valid held stable; S1 holds if full.
//  - Max in-flight = 2; with both stages full and out_ready=0, in_ready=0.
//  - out_count increments by 1 on each output handshake; wraps 2^CNT_WIDTH-1 -> 0.
//  - cnt_clr & handshake same cycle: clear wins, out_count = 0.
//  - Reset (async assert, any time incl. mid-transfer): s1/s2 valid=0, out_res=0, out_zero=0,
//    out_count=0; in-flight data discarded. in_ready=1 while reset deasserted and pipe empty.
//  - out_zero computed on full WIDTH result; all ops are width-agnostic bitwise.
// CONFIGURATION
//  - Macro LOGIC_POPCNT_EN: when defined, adds port out_popcnt out $clog2(WIDTH+1) = number of 1s
//    in out_res, registered in S2 alongside out_res (same latency/stall rules, reset 0).
//  - Undefined: port absent, no popcount logic; all other behaviour identical.
// STRUCTURE
//  - Package logic_pkg: localparam opcodes OP_AND..OP_PASSA (3-bit), typedef logic_op_t.
//  - One sub-module: bitwise_logic_core (combinational WIDTH-param op mux, used in S2 input).
//  - Pipeline stages, handshake and counter live in the top module.
// TESTING
//  1 A=0000A5A5 B=00005A5A op AND, out_ready=1 -> 2 cyc later res=00000000, zero=1, count=1.
//  2 Same A/B, ops OR,XOR,NAND,NOR back-to-back -> 0000FFFF,0000FFFF,FFFFFFFF,FFFF0000, 1/cycle.
//  3 Hold out_ready=0, push 3 txns -> 2 accepted, in_ready=0, out_res stable; release -> order kept.
//  4 Assert rst_n=0 with 2 in flight -> out_valid=0, count=0 immediately; no stale output after.
//  5 CNT_WIDTH=2, 4 handshakes -> count 1,2,3,0; cnt_clr with handshake -> count=0.
//  6 LOGIC_POPCNT_EN, WIDTH=8: A=F0 B=3C op XOR -> res=CC, popcnt=4; op ANDN -> res=C0, popcnt=2.

Source files
------------

// File: rtl/bitwise_logic_pipe_pkg.sv
// logic_pkg: opcode encodings for the pipelined bitwise logic unit
package logic_pkg;
  typedef logic [2:0] logic_op_t;
  localparam logic_op_t OP_AND   = 3'd0;
  localparam logic_op_t OP_OR    = 3'd1;
  localparam logic_op_t OP_XOR   = 3'd2;
  localparam logic_op_t OP_NAND  = 3'd3;
  localparam logic_op_t OP_NOR   = 3'd4;
  localparam logic_op_t OP_XNOR  = 3'd5;
  localparam logic_op_t OP_ANDN  = 3'd6;
  localparam logic_op_t OP_PASSA = 3'd7;
endpackage

// File: rtl/bitwise_logic_pipe_if.sv
// bitwise_logic_pipe_if: operand/result valid-ready bus; LOGIC_POPCNT_EN adds out_popcnt
interface bitwise_logic_pipe_if import logic_pkg::*; #(parameter int WIDTH = 32);
  logic in_valid, in_ready, out_valid, out_ready, out_zero;
  logic [WIDTH-1:0] in_a, in_b, out_res;
  logic_op_t in_op;
`ifdef LOGIC_POPCNT_EN
  logic [$clog2(WIDTH+1)-1:0] out_popcnt;
  modport master(output in_valid, in_a, in_b, in_op, out_ready,
                 input in_ready, out_valid, out_res, out_zero, out_popcnt);
  modport slave(input in_valid, in_a, in_b, in_op, out_ready,
                output in_ready, out_valid, out_res, out_zero, out_popcnt);
`else
  modport master(output in_valid, in_a, in_b, in_op, out_ready,
                 input in_ready, out_valid, out_res, out_zero);
  modport slave(input in_valid, in_a, in_b, in_op, out_ready,
                output in_ready, out_valid, out_res, out_zero);
`endif
endinterface

// File: rtl/bitwise_logic_pipe_core.sv
// bitwise_logic_core: combinational width-agnostic 8-way bitwise op mux
module bitwise_logic_core import logic_pkg::*; #(parameter int WIDTH = 32) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic_op_t        op,
  output logic [WIDTH-1:0] res
);
  always_comb begin
    case (op)
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_NAND: res = ~(a & b);
      OP_NOR:  res = ~(a | b);
      OP_XNOR: res = ~(a ^ b);
      OP_ANDN: res = a & ~b;
      default: res = a;
    endcase
  end
endmodule

// File: rtl/bitwise_logic_pipe.sv
// bitwise_logic_pipe: two-stage valid/ready bitwise logic unit with zero flag and result counter
// LOGIC_POPCNT_EN adds a registered popcount of the result on the bus.
module bitwise_logic_pipe import logic_pkg::*; #(
  parameter int WIDTH = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bitwise_logic_pipe_if.slave  bus,
  input  logic                 cnt_clr,
  output logic [CNT_WIDTH-1:0] out_count
);
  logic s1_valid, s2_valid, s1_adv, s2_adv;
  logic [WIDTH-1:0] s1_a, s1_b, res;
  logic_op_t s1_op;
  assign s2_adv = !s2_valid || bus.out_ready;
  assign s1_adv = !s1_valid || s2_adv;
  assign bus.in_ready = s1_adv;
  assign bus.out_valid = s2_valid;
  bitwise_logic_core #(.WIDTH(WIDTH)) u_core (.a(s1_a), .b(s1_b), .op(s1_op), .res(res));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_op <= OP_AND;
      s2_valid <= 1'b0;
      bus.out_res <= '0;
      bus.out_zero <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1_a <= bus.in_a;
          s1_b <= bus.in_b;
          s1_op <= bus.in_op;
        end
      end
      if (s2_adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          bus.out_res <= res;
          bus.out_zero <= ~|res;
        end
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_count <= '0;
    else if (cnt_clr) out_count <= '0;
    else if (s2_valid && bus.out_ready) out_count <= out_count + CNT_WIDTH'(1);
  end
`ifdef LOGIC_POPCNT_EN
  localparam int PW = $clog2(WIDTH+1);
  logic [PW-1:0] pc;
  always_comb begin
    pc = '0;
    for (int i = 0; i < WIDTH; i++) pc = pc + PW'(res[i]);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bus.out_popcnt <= '0;
    else if (s2_adv && s1_valid) bus.out_popcnt <= pc;
  end
`endif
endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// tb_bitwise_logic_pipe: directed vectors for the default unit plus an 8-bit, 2-bit-counter instance
module tb_bitwise_logic_pipe;
  import logic_pkg::*;
  typedef struct { logic [31:0] a, b; logic_op_t op; logic [31:0] res; logic zero; logic [5:0] pc; } vec_t;
  typedef struct { logic [7:0] a, b; logic_op_t op; logic [7:0] res; logic zero; logic [3:0] pc; } vec8_t;
  logic clk = 1'b0, rst_n = 1'b0, cnt_clr = 1'b0, cnt_clr2 = 1'b0;
  logic [15:0] cnt;
  logic [1:0] cnt2;
  int nvec = 0, nerr = 0, exp_cnt = 0;
  vec_t tv[10];
  vec8_t t8[6];
  int sched[10] = '{0, 1, 2, 3, -1, -1, 4, 5, -1, -1};
  int cnt8[10] = '{0, 0, 1, 2, 3, 0, 0, 0, 1, 0};
  bitwise_logic_pipe_if #(.WIDTH(32)) b();
  bitwise_logic_pipe_if #(.WIDTH(8)) b2();
  bitwise_logic_pipe #(.WIDTH(32), .CNT_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b), .cnt_clr(cnt_clr), .out_count(cnt));
  bitwise_logic_pipe #(.WIDTH(8), .CNT_WIDTH(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2), .cnt_clr(cnt_clr2), .out_count(cnt2));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic drv(input vec_t v);
    b.in_valid = 1'b1;
    b.in_a = v.a;
    b.in_b = v.b;
    b.in_op = v.op;
  endtask
  task automatic chk_out(input string nm, input vec_t v);
    chk({nm, "_valid"}, b.out_valid, 1);
    chk({nm, "_res"}, b.out_res, v.res);
    chk({nm, "_zero"}, b.out_zero, v.zero);
`ifdef LOGIC_POPCNT_EN
    chk({nm, "_popcnt"}, b.out_popcnt, v.pc);
`endif
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    tv[0] = '{32'h0000A5A5, 32'h00005A5A, OP_AND,   32'h00000000, 1'b1, 6'd0};
    tv[1] = '{32'h0000A5A5, 32'h00005A5A, OP_OR,    32'h0000FFFF, 1'b0, 6'd16};
    tv[2] = '{32'h0000A5A5, 32'h00005A5A, OP_XOR,   32'h0000FFFF, 1'b0, 6'd16};
    tv[3] = '{32'h0000A5A5, 32'h00005A5A, OP_NAND,  32'hFFFFFFFF, 1'b0, 6'd32};
    tv[4] = '{32'h0000A5A5, 32'h00005A5A, OP_NOR,   32'hFFFF0000, 1'b0, 6'd16};
    tv[5] = '{32'h0000A5A5, 32'h00005A5A, OP_XNOR,  32'hFFFF0000, 1'b0, 6'd16};
    tv[6] = '{32'h0000A5A5, 32'h00005A5A, OP_ANDN,  32'h0000A5A5, 1'b0, 6'd8};
    tv[7] = '{32'h0000A5A5, 32'h00005A5A, OP_PASSA, 32'h0000A5A5, 1'b0, 6'd8};
    tv[8] = '{32'hFFFFFFFF, 32'hFFFFFFFF, OP_XOR,   32'h00000000, 1'b1, 6'd0};
    tv[9] = '{32'h80000001, 32'h00000001, OP_ANDN,  32'h80000000, 1'b0, 6'd1};
    t8[0] = '{8'hF0, 8'h3C, OP_XOR,   8'hCC, 1'b0, 4'd4};
    t8[1] = '{8'hF0, 8'h3C, OP_ANDN,  8'hC0, 1'b0, 4'd2};
    t8[2] = '{8'hF0, 8'h3C, OP_NAND,  8'hCF, 1'b0, 4'd6};
    t8[3] = '{8'hF0, 8'h0F, OP_AND,   8'h00, 1'b1, 4'd0};
    t8[4] = '{8'hAA, 8'h55, OP_XNOR,  8'h00, 1'b1, 4'd0};
    t8[5] = '{8'h5A, 8'h00, OP_PASSA, 8'h5A, 1'b0, 4'd4};
    b.in_valid = 0; b.in_a = 0; b.in_b = 0; b.in_op = OP_AND; b.out_ready = 1;
    b2.in_valid = 0; b2.in_a = 0; b2.in_b = 0; b2.in_op = OP_AND; b2.out_ready = 1;
    #12;
    chk("rst_valid", b.out_valid, 0);
    chk("rst_res", b.out_res, 0);
    chk("rst_zero", b.out_zero, 0);
    chk("rst_count", cnt, 0);
    chk("rst_count2", cnt2, 0);
    tick();
    rst_n = 1'b1;
    chk("idle_ready", b.in_ready, 1);
    for (int i = 0; i <= 10; i++) begin
      if (i < 10) drv(tv[i]); else b.in_valid = 1'b0;
      tick();
      chk("stream_ready", b.in_ready, 1);
      if (i >= 1) begin
        chk_out($sformatf("stream%0d", i-1), tv[i-1]);
        chk("stream_count", cnt, exp_cnt);
        exp_cnt++;
      end
    end
    tick();
    chk("drain_valid", b.out_valid, 0);
    chk("drain_count", cnt, exp_cnt);
    b.out_ready = 1'b0;
    drv(tv[1]);
    tick();
    chk("stall_ready1", b.in_ready, 1);
    drv(tv[3]);
    tick();
    chk_out("stall_x", tv[1]);
    chk("stall_full", b.in_ready, 0);
    drv(tv[4]);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("stall_hold", tv[1]);
      chk("stall_hold_ready", b.in_ready, 0);
      chk("stall_hold_count", cnt, exp_cnt);
    end
    b.out_ready = 1'b1;
    #1;
    chk("release_ready", b.in_ready, 1);
    tick();
    exp_cnt++;
    chk_out("release_y", tv[3]);
    chk("release_count", cnt, exp_cnt);
    b.in_valid = 1'b0;
    tick();
    exp_cnt++;
    chk_out("release_z", tv[4]);
    tick();
    exp_cnt++;
    chk("release_empty", b.out_valid, 0);
    chk("release_count2", cnt, exp_cnt);
    b.out_ready = 1'b0;
    drv(tv[5]);
    tick();
    drv(tv[6]);
    tick();
    b.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", b.out_valid, 0);
    chk("arst_count", cnt, 0);
    chk("arst_res", b.out_res, 0);
    chk("arst_ready", b.in_ready, 1);
    tick();
    rst_n = 1'b1;
    b.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("arst_no_stale", b.out_valid, 0);
    end
    drv(tv[7]);
    tick();
    drv(tv[8]);
    tick();
    b.in_valid = 1'b0;
    tick();
    chk_out("clr_pre", tv[8]);
    chk("clr_pre_count", cnt, 1);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_count", cnt, 0);
    chk("clr_valid", b.out_valid, 0);
    for (int k = 0; k < 10; k++) begin
      b2.in_valid = sched[k] >= 0;
      if (sched[k] >= 0) begin
        b2.in_a = t8[sched[k]].a;
        b2.in_b = t8[sched[k]].b;
        b2.in_op = t8[sched[k]].op;
      end
      cnt_clr2 = k == 9;
      tick();
      chk($sformatf("w8_count%0d", k), cnt2, cnt8[k]);
      chk($sformatf("w8_valid%0d", k), b2.out_valid, k > 0 && sched[k-1] >= 0);
      if (k > 0 && sched[k-1] >= 0) begin
        chk($sformatf("w8_res%0d", k), b2.out_res, t8[sched[k-1]].res);
        chk($sformatf("w8_zero%0d", k), b2.out_zero, t8[sched[k-1]].zero);
`ifdef LOGIC_POPCNT_EN
        chk($sformatf("w8_popcnt%0d", k), b2.out_popcnt, t8[sched[k-1]].pc);
`endif
      end
    end
    cnt_clr2 = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
